// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: instruction width, fetch FSM encodings
// and the misaligned-fetch test used by the fetch unit.
package riscv_pkg;

  localparam int INSTR_W = 32;

  localparam logic [1:0] FETCH_IDLE = 2'd0;
  localparam logic [1:0] FETCH_WAIT = 2'd1;
  localparam logic [1:0] FETCH_DROP = 2'd2;

  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Circular fetch queue with occupancy count; flush wins over push and pop.
// Storage is deliberately left unreset, only the pointers and count reset.
module riscv_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain modular overflow
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push_i) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (pop_i) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (push_i && !pop_i) begin
        r_count <= r_count + CNT_W'(1);
      end else if (pop_i && !push_i) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign data_o  = r_mem[r_rptr];
  assign count_o = r_count;

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction fetch unit: one outstanding memory read, small decode queue, branch flush.
// Define RISCV_IFETCH_MISALIGN_CHK_EN to tag fetches whose address is not word aligned.
module riscv_ifetch
  import riscv_pkg::*;
#(
  parameter int PC_SIZE  = 32,
  parameter int FQ_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [PC_SIZE-1:0] pc_addr_i,
  output logic               ird_o,
  input  logic               branch_taken_i,
  output logic               imem_req_o,
  output logic [PC_SIZE-1:0] imem_addr_o,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               id_valid_o,
  input  logic               id_ready_i,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [PC_SIZE-1:0] id_pc_o,
  output logic               id_fault_o
);

  localparam int CNT_W = $clog2(FQ_DEPTH+1);
`ifdef RISCV_IFETCH_MISALIGN_CHK_EN
  localparam int ENTRY_W = PC_SIZE + INSTR_W + 1;
`else
  localparam int ENTRY_W = PC_SIZE + INSTR_W;
`endif

  logic [1:0]         r_state;
  logic [PC_SIZE-1:0] r_addr;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_count_after_pop;
  logic               w_valid;
  logic               w_pop;
  logic               w_push;
  logic               w_issue;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;

  assign w_valid           = (w_count != '0);
  assign w_pop             = w_valid && id_ready_i;
  assign w_count_after_pop = w_count - {{(CNT_W-1){1'b0}}, w_pop};
  // A branch flushes the queue, so it always leaves room for the jump target
  assign w_issue = reset_i && (r_state == FETCH_IDLE) &&
                   (branch_taken_i || (w_count_after_pop < CNT_W'(FQ_DEPTH)));
  assign w_push  = (r_state == FETCH_WAIT) && imem_rvalid_i && !branch_taken_i;

  assign imem_req_o  = w_issue;
  assign imem_addr_o = pc_addr_i;
  assign ird_o       = reset_i && (w_issue || branch_taken_i);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= FETCH_IDLE;
    end else begin
      case (r_state)
        FETCH_IDLE: if (w_issue) r_state <= FETCH_WAIT;
        FETCH_WAIT: begin
          if (imem_rvalid_i) begin
            r_state <= FETCH_IDLE;
          end else if (branch_taken_i) begin
            r_state <= FETCH_DROP;
          end
        end
        FETCH_DROP: if (imem_rvalid_i) r_state <= FETCH_IDLE;
        default:    r_state <= FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_addr <= '0;
    end else if (w_issue) begin
      r_addr <= pc_addr_i;
    end
  end

`ifdef RISCV_IFETCH_MISALIGN_CHK_EN
  logic r_fault;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_fault <= 1'b0;
    end else if (w_issue) begin
      r_fault <= is_misaligned(pc_addr_i[1:0]);
    end
  end

  assign w_wdata    = {r_fault, r_addr, imem_rdata_i};
  assign id_fault_o = w_valid && w_rdata[ENTRY_W-1];
`else
  assign w_wdata    = {r_addr, imem_rdata_i};
  assign id_fault_o = 1'b0;
`endif

  riscv_fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (branch_taken_i),
    .data_i  (w_wdata),
    .data_o  (w_rdata),
    .count_o (w_count)
  );

  assign id_valid_o = w_valid;
  assign id_instr_o = w_rdata[INSTR_W-1:0];
  assign id_pc_o    = w_rdata[INSTR_W +: PC_SIZE];

endmodule

// File: tb/tb_riscv_ifetch.sv
// Self-checking bench for riscv_ifetch: queue-based reference model, bench-side
// program counter and variable-latency memory, directed scenarios plus random traffic.
module tb_riscv_ifetch;

  localparam int PC_SIZE  = 32;
  localparam int FQ_DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [31:0] pc_addr_i = '0;
  logic        ird_o;
  logic        branch_taken_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_fault_o;

  riscv_ifetch #(.PC_SIZE(PC_SIZE), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .pc_addr_i      (pc_addr_i),
    .ird_o          (ird_o),
    .branch_taken_i (branch_taken_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .id_valid_o     (id_valid_o),
    .id_ready_i     (id_ready_i),
    .id_instr_o     (id_instr_o),
    .id_pc_o        (id_pc_o),
    .id_fault_o     (id_fault_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } entry_t;
  typedef struct { int due; logic [31:0] data; } resp_t;

  int total = 0;
  int bad = 0;

  entry_t      modelQ[$];
  bit          modelBusy;
  bit          modelDrop;
  logic [31:0] modelAddr;
  logic        modelFault;

  resp_t       memSched[$];
  int          cycleNo = 0;
  int          reqSeq = 0;
  logic [31:0] pcReg = '0;

  bit          drvReset = 1'b0;
  bit          drvBranch = 1'b0;
  logic [31:0] drvTarget = '0;
  bit          drvReady = 1'b0;
  int          drvLat = 1;

  logic [31:0] issAddr[$];
  int          issCyc[$];
  logic [31:0] popPc[$];
  logic        popFault[$];
  int          firstValidCyc = -1;

  function automatic logic expFaultOf(input logic [31:0] pc);
`ifdef RISCV_IFETCH_MISALIGN_CHK_EN
    return pc[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] addr, input int seq);
    return (addr * 32'h9E37_79B1) ^ (32'(seq) << 20) ^ 32'h0000_5A5A;
  endfunction

  function automatic void checkOutput(input string name, input logic [63:0] act,
                                      input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycleNo);
    end
  endfunction

  // One clock: drive inputs, compare at the falling edge, then advance model and environment
  task automatic applyStimulus();
    bit          rv;
    logic [31:0] rd;
    logic [31:0] curPc;
    bit          expValid;
    bit          expPop;
    bit          expIssue;
    int          freeSlots;
    entry_t      e;
    rv = 1'b0;
    rd = $urandom();
    if (memSched.size() > 0 && memSched[0].due == cycleNo) begin
      rv = 1'b1;
      rd = memSched[0].data;
      void'(memSched.pop_front());
    end
    curPc = drvBranch ? drvTarget : pcReg;
    reset_i        = drvReset;
    branch_taken_i = drvBranch;
    id_ready_i     = drvReady;
    imem_rvalid_i  = rv;
    imem_rdata_i   = rd;
    pc_addr_i      = curPc;
    @(negedge clk_i);
    if (!drvReset) begin
      checkOutput("rstReq", 64'(imem_req_o), 64'd0);
      checkOutput("rstIrd", 64'(ird_o), 64'd0);
      checkOutput("rstValid", 64'(id_valid_o), 64'd0);
      checkOutput("rstFault", 64'(id_fault_o), 64'd0);
      modelQ.delete();
      modelBusy = 1'b0;
      modelDrop = 1'b0;
      pcReg = '0;
    end else begin
      expValid  = modelQ.size() != 0;
      expPop    = expValid && drvReady;
      freeSlots = FQ_DEPTH - modelQ.size() + (expPop ? 1 : 0);
      expIssue  = !modelBusy && (drvBranch || freeSlots > 0);
      checkOutput("req", 64'(imem_req_o), 64'(expIssue));
      checkOutput("ird", 64'(ird_o), 64'(expIssue || drvBranch));
      checkOutput("valid", 64'(id_valid_o), 64'(expValid));
      if (expIssue) checkOutput("addr", 64'(imem_addr_o), 64'(curPc));
      if (expValid) begin
        checkOutput("headPc", 64'(id_pc_o), 64'(modelQ[0].pc));
        checkOutput("headInstr", 64'(id_instr_o), 64'(modelQ[0].instr));
        checkOutput("headFault", 64'(id_fault_o), 64'(modelQ[0].fault));
      end
      if (imem_req_o) begin
        issAddr.push_back(imem_addr_o);
        issCyc.push_back(cycleNo);
      end
      if (id_valid_o && id_ready_i) begin
        popPc.push_back(id_pc_o);
        popFault.push_back(id_fault_o);
      end
      if (id_valid_o && firstValidCyc < 0) firstValidCyc = cycleNo;

      if (expPop) void'(modelQ.pop_front());
      if (modelBusy && rv) begin
        if (!modelDrop && !drvBranch) begin
          e.pc = modelAddr;
          e.instr = rd;
          e.fault = modelFault;
          modelQ.push_back(e);
        end
        modelBusy = 1'b0;
        modelDrop = 1'b0;
      end else if (modelBusy && drvBranch) begin
        modelDrop = 1'b1;
      end
      if (drvBranch) modelQ.delete();
      if (expIssue) begin
        modelBusy  = 1'b1;
        modelDrop  = 1'b0;
        modelAddr  = curPc;
        modelFault = expFaultOf(curPc);
        reqSeq++;
        memSched.push_back('{cycleNo + drvLat, memWord(curPc, reqSeq)});
      end
      pcReg = expIssue ? curPc + 32'd4 : (drvBranch ? drvTarget : pcReg);
    end
    @(posedge clk_i);
    #1;
    cycleNo++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic doReset();
    drvBranch = 1'b0;
    drvReset = 1'b0;
    runCycles(2);
    memSched.delete();
    issAddr.delete();
    issCyc.delete();
    popPc.delete();
    popFault.delete();
    firstValidCyc = -1;
    drvReset = 1'b1;
  endtask

  task automatic waitIssueOf(input logic [31:0] addr, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus();
      if (modelBusy && modelAddr == addr) found = 1'b1;
    end
    checkOutput(name, 64'(found), 64'd1);
  endtask

  initial begin
    int idx;
    int baseIss;

    // Sequential fetch with single-cycle memory
    doReset();
    drvLat = 1;
    drvReady = 1'b1;
    runCycles(8);
    checkOutput("seqAddr0", 64'(issAddr[0]), 64'h0);
    checkOutput("seqAddr1", 64'(issAddr[1]), 64'h4);
    checkOutput("seqAddr2", 64'(issAddr[2]), 64'h8);
    checkOutput("seqGap1", 64'(issCyc[1] - issCyc[0]), 64'd2);
    checkOutput("seqGap2", 64'(issCyc[2] - issCyc[1]), 64'd2);
    checkOutput("seqLatency", 64'(firstValidCyc - issCyc[0]), 64'd2);
    checkOutput("seqFirstPc", 64'(popPc[0]), 64'h0);

    // Back-pressure fills the queue and stalls requests
    doReset();
    drvReady = 1'b0;
    runCycles(6);
    checkOutput("bpIssues", 64'(issAddr.size()), 64'd2);
    checkOutput("bpCount", 64'(dut.u_fifo.count_o), 64'd2);
    checkOutput("bpReqHeld", 64'(imem_req_o), 64'd0);
    drvReady = 1'b1;
    runCycles(6);
    checkOutput("bpPop0", 64'(popPc[0]), 64'h0);
    checkOutput("bpPop1", 64'(popPc[1]), 64'h4);
    checkOutput("bpResume", 64'(issAddr[2]), 64'h8);

    // Branch while waiting on a slow response drops that response
    doReset();
    drvLat = 3;
    drvReady = 1'b1;
    waitIssueOf(32'h8, "brWaitTimeout");
    drvBranch = 1'b1;
    drvTarget = 32'h100;
    applyStimulus();
    drvBranch = 1'b0;
    runCycles(15);
    checkOutput("brNextReq", 64'(issAddr[3]), 64'h100);
    checkOutput("brPop1", 64'(popPc[1]), 64'h4);
    checkOutput("brPop2", 64'(popPc[2]), 64'h100);

    // Branch coincident with a response and a pop
    doReset();
    drvLat = 1;
    drvReady = 1'b0;
    waitIssueOf(32'h4, "coWaitTimeout");
    drvReady = 1'b1;
    drvBranch = 1'b1;
    drvTarget = 32'h200;
    applyStimulus();
    drvBranch = 1'b0;
    checkOutput("coEmpty", 64'(id_valid_o), 64'd0);
    runCycles(10);
    checkOutput("coReq", 64'(issAddr[2]), 64'h200);
    checkOutput("coGap", 64'(issCyc[2] - issCyc[1]), 64'd2);
    checkOutput("coPop0", 64'(popPc[0]), 64'h0);
    checkOutput("coPop1", 64'(popPc[1]), 64'h200);

    // Misaligned branch target
    doReset();
    drvLat = 1;
    drvReady = 1'b1;
    runCycles(3);
    drvBranch = 1'b1;
    drvTarget = 32'h102;
    applyStimulus();
    drvBranch = 1'b0;
    runCycles(8);
    idx = -1;
    foreach (popPc[i]) if (idx < 0 && popPc[i] == 32'h102) idx = i;
    checkOutput("misFound", 64'(idx >= 0), 64'd1);
    if (idx >= 0) begin
`ifdef RISCV_IFETCH_MISALIGN_CHK_EN
      checkOutput("misFault", 64'(popFault[idx]), 64'd1);
`else
      checkOutput("misFault", 64'(popFault[idx]), 64'd0);
`endif
    end

    // Reset in the middle of a request; the stale response lands after release
    doReset();
    drvLat = 2;
    drvReady = 1'b1;
    applyStimulus();
    drvReset = 1'b0;
    applyStimulus();
    drvReset = 1'b1;
    baseIss = issAddr.size();
    runCycles(8);
    checkOutput("rstMidIssue", 64'(issAddr[baseIss]), 64'h0);
    checkOutput("rstMidLatency", 64'(firstValidCyc - issCyc[baseIss]), 64'd3);
    checkOutput("rstMidPop", 64'(popPc[0]), 64'h0);

    // Random traffic against the model
    doReset();
    for (int i = 0; i < 1500; i++) begin
      drvBranch = ($urandom_range(0, 99) < 5);
      drvTarget = {18'd0, 12'($urandom_range(0, 4095)), 2'b00} +
                  (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd0);
      drvReady  = ($urandom_range(0, 9) < 7);
      drvLat    = $urandom_range(1, 4);
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_ifetch.md
RISCV_IFETCH -- requirements
Module: riscv_ifetch

Interface
REQ-001 SHALL have parameter PC_SIZE, default 32, address width.
REQ-002 SHALL have parameter FQ_DEPTH, default 2, fetch-queue entries (power of two, >=2).
REQ-003 SHALL have port clk_i input 1, single clock; all state on rising edge.
REQ-004 SHALL have port reset_i input 1, reset, asynchronous, active-low.
REQ-005 SHALL have port pc_addr_i input PC_SIZE, next fetch address from program counter.
REQ-006 SHALL have port ird_o output 1, advance/load request to program counter.
REQ-007 SHALL have port branch_taken_i input 1, redirect pulse, also seen by program counter.
REQ-008 SHALL have port imem_req_o output 1, instruction-memory read request.
REQ-009 SHALL have port imem_addr_o output PC_SIZE, request address, equals pc_addr_i.
REQ-010 SHALL have port imem_rvalid_i input 1, read data valid, one or more cycles after request.
REQ-011 SHALL have port imem_rdata_i input 32, instruction word.
REQ-012 SHALL have port id_valid_o output 1, queue head valid to decode.
REQ-013 SHALL have port id_ready_i input 1, decode accepts head.
REQ-014 SHALL have port id_instr_o output 32, head instruction.
REQ-015 SHALL have port id_pc_o output PC_SIZE, head address.
REQ-016 SHALL have port id_fault_o output 1, head misaligned-fetch flag.

Function
REQ-017 SHALL run an FSM: IDLE (no request outstanding), WAIT (one outstanding), DROP (outstanding, response to discard).
REQ-018 SHALL issue (imem_req_o=1) only in IDLE when free slots after this cycle's pop exceed zero; at most one outstanding request.
REQ-019 SHALL drive ird_o = issue OR branch_taken_i, so the counter loads the jump address even while waiting.
REQ-020 SHALL capture {pc_addr_i, fault} at issue and transition IDLE->WAIT.
REQ-021 SHALL in WAIT on imem_rvalid_i push {addr, imem_rdata_i, fault} and go IDLE; id_valid_o rises the next cycle (issue-to-valid latency min 2).
REQ-022 SHALL keep occupancy counter 0..FQ_DEPTH with circular read/write pointers wrapping modulo FQ_DEPTH; push and pop same cycle leave count unchanged.
REQ-023 SHALL pop when id_valid_o AND id_ready_i; id_valid_o = (count != 0).
REQ-024 SHALL on branch_taken_i flush queue (count=0, pointers equal) with priority over push/pop.
REQ-025 SHALL on branch in IDLE issue pc_addr_i (jump address) the same cycle.
REQ-026 SHALL on branch in WAIT without rvalid go DROP; with rvalid same cycle discard data, go IDLE.
REQ-027 SHALL in DROP discard the response on imem_rvalid_i and go IDLE; branch in DROP stays DROP unless rvalid.
REQ-028 SHALL ignore imem_rvalid_i in IDLE.

Reset
REQ-029 SHALL on reset_i low force state IDLE, count 0, pointers 0, id_valid_o 0, id_fault_o 0, imem_req_o 0, ird_o 0; queue data unreset.
REQ-030 SHALL treat reset mid-WAIT as abandoning the request; a late imem_rvalid_i after release is ignored in IDLE.

Configuration
REQ-031 SHALL with RISCV_IFETCH_MISALIGN_CHK_EN defined set fault = (pc_addr_i[1:0] != 0) at issue; without it id_fault_o is constant 0 and no fault storage exists.

Structure
REQ-032 SHALL take FSM state encodings and the instruction width constant from the shared riscv package.
REQ-033 SHALL place the queue in sub-module riscv_fetch_fifo (push, pop, flush, count).

Verification
REQ-034 Reset release, PC reset 0x0, 1-cycle memory, id_ready_i=1 -> imem_addr_o 0x0,0x4,0x8 every 2 cycles; id_pc_o=0x0 valid 2 cycles after first request.
REQ-035 id_ready_i=0 -> after 2 responses count=2, imem_req_o held 0; ready=1 -> pops 0x0 then 0x4, fetch resumes at 0x8.
REQ-036 Branch to 0x100 while WAIT on 0x8 (3-cycle memory) -> data for 0x8 never presented, next imem_addr_o=0x100, id_pc_o=0x100.
REQ-037 Branch to 0x200 coincident with rvalid for 0x4 and a pending pop -> queue empty, next request 0x200, no 0x4 entry.
REQ-038 Branch to 0x102 -> id_fault_o=1 at id_pc_o=0x102 with macro, 0 without.
REQ-039 Reset asserted in WAIT, rvalid one cycle after release -> no push, id_valid_o 0, first request 0x0.
